// File: rtl/fetch_queue.sv
// fetch_queue: pipelined instruction prefetch unit. It keeps up to DEPTH
// sequential reads either in flight or buffered, drops responses that belong
// to requests issued before a redirect, and turns a misaligned redirect
// target into a single marker entry for the controller to trap on.
module fetch_queue #(
  parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memory_ready,
  input  logic                     memory_valid,
  input  logic [31:0]              read_memory_data,
  output logic [31:0]              read_memory_address,
  output logic                     memory_command,
  output logic                     memory_enable,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [31:0]              fetch_instruction,
  output logic [31:0]              fetch_pc,
  output logic                     fetch_misaligned,
  output logic [$clog2(DEPTH):0]   debug_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // buffer storage
  logic [31:0]   r_buf_pc    [DEPTH];
  logic [31:0]   r_buf_instr [DEPTH];
  logic          r_buf_mis   [DEPTH];

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;
  logic [31:0]   r_issue_pc;
  logic [31:0]   r_resp_pc;
  logic          r_halted;
  // a misaligned redirect is waiting for stale responses to drain before its
  // marker entry can be enqueued; no reads are issued meanwhile
  logic          r_mis_pending;

  logic          w_room;
  logic          w_enable;
  logic          w_accept;
  logic          w_resp;
  logic          w_keep;
  logic          w_marker;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_inflight_next;
  logic [CW-1:0] w_occ_next;

  // issue, response and pop decisions for this cycle
  always_comb begin
    w_room   = ((CW+1)'(r_occ) + (CW+1)'(r_inflight)) < (CW+1)'(DEPTH);
    w_enable = !reset && !redirect && !r_halted && !r_mis_pending && w_room;
    w_accept = w_enable && memory_ready;
    // a response with nothing outstanding is a protocol violation and is ignored
    w_resp   = memory_valid && (r_inflight != '0);
    w_keep   = w_resp && (r_discard == '0) && !redirect;
    w_marker = r_mis_pending && (r_discard == '0) && !w_keep && !redirect;
    w_push   = w_keep || w_marker;
    w_pop    = (r_occ != '0) && fetch_ready && !redirect;
    w_inflight_next = r_inflight + CW'(w_accept) - CW'(w_resp);
    w_occ_next      = r_occ + CW'(w_push) - CW'(w_pop);
  end

  // buffer entries; the marker's pc is the response pc, which still holds the
  // redirect target because no response has been kept since
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_pc[i]    <= START_ADDRESS;
        r_buf_instr[i] <= 32'h0;
        r_buf_mis[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_buf_pc[r_wr_ptr]    <= r_resp_pc;
      r_buf_instr[r_wr_ptr] <= w_marker ? 32'h0 : read_memory_data;
      r_buf_mis[r_wr_ptr]   <= w_marker;
    end
  end

  // control state: pointers, counters, program counters and halt tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_occ         <= '0;
      r_inflight    <= '0;
      r_discard     <= '0;
      r_issue_pc    <= START_ADDRESS;
      r_resp_pc     <= START_ADDRESS;
      r_halted      <= 1'b0;
      r_mis_pending <= 1'b0;
    end else if (redirect) begin
      // every read still outstanding after this cycle belongs to the old stream
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_occ         <= '0;
      r_inflight    <= w_inflight_next;
      r_discard     <= w_inflight_next;
      r_issue_pc    <= redirect_pc;
      r_resp_pc     <= redirect_pc;
      r_halted      <= 1'b0;
      r_mis_pending <= |redirect_pc[1:0];
    end else begin
      r_inflight <= w_inflight_next;
      r_occ      <= w_occ_next;
      if (w_resp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
      if (w_accept) r_issue_pc <= r_issue_pc + 32'd4;
      if (w_keep)   r_resp_pc  <= r_resp_pc + 32'd4;
      if (w_push)   r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_marker) begin
        r_mis_pending <= 1'b0;
        r_halted      <= 1'b1;
      end
    end
  end

  assign memory_enable       = w_enable;
  assign memory_command      = 1'b0;
  assign read_memory_address = r_issue_pc;
  assign fetch_valid         = (r_occ != '0);
  assign fetch_pc            = r_buf_pc[r_rd_ptr];
  assign fetch_instruction   = r_buf_instr[r_rd_ptr];
  assign fetch_misaligned    = r_buf_mis[r_rd_ptr];
  assign debug_count         = r_occ;

endmodule
